// File: rtl/sad_search_ctrl_if.sv
// Bundle of candidate-issue, compare-side and control signals between
// sad_search_ctrl (master) and the SAD datapath / ME controller (slave).
// Optional feature macro: EARLY_TERM_EN adds early_term, best_sad16, et_thresh.
interface sad_search_ctrl_if #(
  parameter int MV_W = 7
);
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   cand_valid;
  logic                   cand_ready;
  logic signed [MV_W-1:0] cand_x;
  logic signed [MV_W-1:0] cand_y;
  logic                   min_clr;
  logic                   cmp_en;
  logic signed [MV_W-1:0] cmp_mv_x;
  logic signed [MV_W-1:0] cmp_mv_y;
`ifdef EARLY_TERM_EN
  logic                   early_term;
  logic [63:0]            best_sad16;
  logic [15:0]            et_thresh;
`endif

  modport master (
    input  start,
    input  cand_ready,
`ifdef EARLY_TERM_EN
    input  best_sad16,
    input  et_thresh,
    output early_term,
`endif
    output busy,
    output done,
    output cand_valid,
    output cand_x,
    output cand_y,
    output min_clr,
    output cmp_en,
    output cmp_mv_x,
    output cmp_mv_y
  );

  modport slave (
    output start,
    output cand_ready,
`ifdef EARLY_TERM_EN
    output best_sad16,
    output et_thresh,
    input  early_term,
`endif
    input  busy,
    input  done,
    input  cand_valid,
    input  cand_x,
    input  cand_y,
    input  min_clr,
    input  cmp_en,
    input  cmp_mv_x,
    input  cmp_mv_y
  );
endinterface

// File: rtl/sad_search_ctrl.sv
// Integer-pel full-search sequencer. Walks the candidate raster
// x,y in [-SR, SR-1] (x fastest), hands each MV to the SAD tree over a
// valid/ready handshake, and delays accepted MVs by PIPE_LAT cycles so
// cmp_en/cmp_mv line up with the SADs arriving at the min-SAD comparators.
// Optional feature macro: EARLY_TERM_EN (stop issuing once all four
// SAD16x16 minima fall below et_thresh).
// Requires SR <= 2**(MV_W-1) and PIPE_LAT >= 1.
module sad_search_ctrl #(
  parameter int SR       = 32,
  parameter int MV_W     = 7,
  parameter int PIPE_LAT = 4
) (
  input logic               clk,
  input logic               rst_n,
  sad_search_ctrl_if.master bus
);

  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SR);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SR - 1);
  localparam logic signed [MV_W-1:0] MV_ONE = MV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                   vld;
    logic signed [MV_W-1:0] x;
    logic signed [MV_W-1:0] y;
  } stage_t;

  state_t                 state;
  logic                   busy_q;
  logic                   done_q;
  logic                   min_clr_q;
  logic                   cand_valid_q;
  logic signed [MV_W-1:0] cand_x_q;
  logic signed [MV_W-1:0] cand_y_q;
  // Raster position; rests at (-SR,-SR) while the MV outputs rest at zero.
  logic signed [MV_W-1:0] pos_x;
  logic signed [MV_W-1:0] pos_y;
  logic signed [MV_W-1:0] nxt_x;
  logic signed [MV_W-1:0] nxt_y;
  logic                   last_pos;
  logic                   accept;
  logic                   dl_busy;
  logic                   et_hit;
  stage_t                 dl [PIPE_LAT];
`ifdef EARLY_TERM_EN
  logic                   early_term_q;
`endif

  assign accept   = cand_valid_q & bus.cand_ready;
  assign last_pos = (pos_x == MV_MAX) && (pos_y == MV_MAX);

  // Next raster position: x advances, wrapping to -SR with a y step at the row end.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    nxt_x = pos_x + MV_ONE;
    nxt_y = pos_y;
    if (pos_x == MV_MAX) begin
      nxt_x = MV_MIN;
      nxt_y = pos_y + MV_ONE;
    end
  end

  // Anything still heading for the comparators after this edge (all stages
  // but the last, plus an accept landing in stage 0) keeps DRAIN waiting.
  always_comb begin
    dl_busy = accept;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      dl_busy = dl_busy | dl[i].vld;
    end
  end

`ifdef EARLY_TERM_EN
  // Early-termination test: all four lane minima strictly below threshold.
  always_comb begin
    et_hit = (state == S_SCAN);
    for (int l = 0; l < 4; l++) begin
      if (bus.best_sad16[16*l +: 16] >= bus.et_thresh) et_hit = 1'b0;
    end
  end
`else
  assign et_hit = 1'b0;
`endif

  // Search FSM with registered outputs and the raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with non-blocking assignments only, so every
    // read in this block sees the pre-edge value regardless of statement order.
    if (!rst_n) begin
      state        <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      min_clr_q    <= 1'b0;
      cand_valid_q <= 1'b0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      pos_x        <= MV_MIN;
      pos_y        <= MV_MIN;
`ifdef EARLY_TERM_EN
      early_term_q <= 1'b0;
`endif
    end else begin
      min_clr_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_CLR;
            busy_q    <= 1'b1;
            min_clr_q <= 1'b1;
`ifdef EARLY_TERM_EN
            early_term_q <= 1'b0;
`endif
          end
        end
        S_CLR: begin
          state        <= S_SCAN;
          pos_x        <= MV_MIN;
          pos_y        <= MV_MIN;
          cand_x_q     <= MV_MIN;
          cand_y_q     <= MV_MIN;
          cand_valid_q <= 1'b1;
        end
        S_SCAN: begin
          if (accept && !last_pos) begin
            pos_x    <= nxt_x;
            pos_y    <= nxt_y;
            cand_x_q <= nxt_x;
            cand_y_q <= nxt_y;
          end
          if ((accept && last_pos) || et_hit) begin
            state        <= S_DRAIN;
            cand_valid_q <= 1'b0;
`ifdef EARLY_TERM_EN
            if (et_hit) early_term_q <= 1'b1;
`endif
          end
        end
        S_DRAIN: begin
          if (!dl_busy) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          busy_q       <= 1'b0;
          cand_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // MV delay line: shifts every cycle, never stalls, loads accepts at stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the delay line is reset in full; a reset mid-search must flush
    // in-flight valids, and clearing the MV fields too keeps cmp_mv at zero.
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= '{vld: accept, x: cand_x_q, y: cand_y_q};
      for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.min_clr    = min_clr_q;
  assign bus.cand_valid = cand_valid_q;
  assign bus.cand_x     = cand_x_q;
  assign bus.cand_y     = cand_y_q;
  assign bus.cmp_en     = dl[PIPE_LAT-1].vld;
  assign bus.cmp_mv_x   = dl[PIPE_LAT-1].x;
  assign bus.cmp_mv_y   = dl[PIPE_LAT-1].y;
`ifdef EARLY_TERM_EN
  assign bus.early_term = early_term_q;
`endif

endmodule
